uart_tx: RTL

- UART transmitter; the transmit-side partner of the existing UART receiver in the UART IP.
- Serializes one byte per request: start bit, 8 data bits LSB first, odd parity bit, stop bit.
- The frame format matches what the receiver samples and checks (parity bit = XNOR of data bits).
- Request/acknowledge uses a 4-phase Send/Sent handshake, mirroring the receiver's Receive/Received pair.

---
 rtl/uart_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx - UART transmitter, transmit-side partner of the UART receiver.
//
// Sends one byte per request as: start bit (0), 8 data bits LSB first,
// odd parity bit (XNOR of the data bits), stop bit (1). Each bit is held for
// BAUD_CLOCKS = CLK_FREQ / BAUD_RATE system clocks.
//
// Configuration macro:
//   UART_TX_PARITY_EN  defined   -> 11-bit frame with parity (8O1)
//                      undefined -> 10-bit frame, no parity bit (8N1)
//
// Ports:
//   clk      system clock, all state on the rising edge
//   Reset_n  asynchronous active-low reset (line returns high immediately)
//   Send     transmit request, level-based 4-phase handshake
//   Din      byte to send, captured on the IDLE -> START transition only
//   Sout     registered serial line, idles high
//   Busy     high in every state except IDLE
//   Sent     frame-complete acknowledge, high only in ACK
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 19_200
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       Send,
    input  logic [7:0] Din,
    output logic       Sout,
    output logic       Busy,
    output logic       Sent
);

    localparam int BAUD_CLOCKS = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W       = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CLOCKS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        ACK    = 3'd5
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       data_r;
    logic             sout_r;
    logic             bit_done_s;
`ifdef UART_TX_PARITY_EN
    logic             parity_r;
`endif

    // Odd parity as the receiver checks it: bit is 1 when the data has an
    // even number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    assign bit_done_s = (baud_cnt_r == CNT_LAST);

    assign Sout = sout_r;
    assign Busy = (state_r != IDLE);
    assign Sent = (state_r == ACK);

    // Frame sequencer: state, baud timer, bit index, shift register and the
    // registered serial line all move together on each edge.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            data_r     <= 8'd0;
            sout_r     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= '0;
                    bit_idx_r  <= 3'd0;
                    if (Send) begin
                        data_r   <= Din;
`ifdef UART_TX_PARITY_EN
                        parity_r <= odd_parity(Din);
`endif
                        sout_r   <= 1'b0;
                        state_r  <= START;
                    end else begin
                        sout_r   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        baud_cnt_r <= '0;
                        bit_idx_r  <= 3'd0;
                        sout_r     <= data_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        baud_cnt_r <= '0;
                        // Shift so the next bit is always at data_r[0]; the
                        // line is loaded from data_r[1] = next bit pre-shift.
                        data_r     <= {1'b0, data_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            sout_r  <= parity_r;
                            state_r <= PARITY;
`else
                            sout_r  <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            sout_r    <= data_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done_s) begin
                        baud_cnt_r <= '0;
                        sout_r     <= 1'b1;
                        state_r    <= STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done_s) begin
                        baud_cnt_r <= '0;
                        sout_r     <= 1'b1;
                        state_r    <= ACK;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                ACK: begin
                    baud_cnt_r <= '0;
                    sout_r     <= 1'b1;
                    // Hold the acknowledge until the requester drops Send.
                    if (!Send) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ACK;
                    end
                end
                default: begin
                    baud_cnt_r <= '0;
                    bit_idx_r  <= 3'd0;
                    sout_r     <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule
